// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake game sequencing logic.
package snake_pkg;

  typedef enum logic [2:0] {
    MV_RIGHT = 3'b000,
    MV_UP    = 3'b001,
    MV_LEFT  = 3'b010,
    MV_DOWN  = 3'b011,
    MV_HOLD  = 3'b100
  } move_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DEAD
  } game_state_t;

  localparam int unsigned CELL_DEF  = 20;
  localparam int unsigned X_MAX_DEF = 620;
  localparam int unsigned Y_MAX_DEF = 460;

  // Right/left and up/down differ only in bit 1 of their codes.
  function automatic logic is_reverse(input move_t a, input move_t b);
    return (a[2] == 1'b0) && (b[2] == 1'b0) && ((a ^ b) == 3'b010);
  endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the game controller and the snake datapath.
interface snake_game_ctrl_if;
  logic       start;
  logic       btn_right;
  logic       btn_up;
  logic       btn_left;
  logic       btn_down;
  logic [9:0] head_x;
  logic [9:0] head_y;
  logic       self_hit;
  logic       apple_hit;
  logic [2:0] move;
  logic       step;
  logic       running;
  logic       lose;
  logic [7:0] score;

  // Datapath / stimulus side.
  modport master (
    output start, btn_right, btn_up, btn_left, btn_down,
    output head_x, head_y, self_hit, apple_hit,
    input  move, step, running, lose, score
  );

  // Controller side.
  modport slave (
    input  start, btn_right, btn_up, btn_left, btn_down,
    input  head_x, head_y, self_hit, apple_hit,
    output move, step, running, lose, score
  );
endinterface

// File: rtl/snake_tick_gen.sv
// Movement tick divider: counts 0..TICK_DIV-1 while enabled, one-cycle tick on the last count.
module snake_tick_gen #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned   CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: synchronous clear has priority, otherwise wrap at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)              cnt_d = '0;
    else if (cnt_q == LAST) cnt_d = '0;
    else                    cnt_d = cnt_q + 1'b1;
  end

  assign tick_o = !clr_i && (cnt_q == LAST);

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: run/dead FSM, direction arbitration, wall/self collision, score.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned TICK_DIV = 6_250_000,
  parameter int unsigned CELL     = CELL_DEF,
  parameter int unsigned X_MAX    = X_MAX_DEF,
  parameter int unsigned Y_MAX    = Y_MAX_DEF
) (
  input  logic              clk25,
  input  logic              rst_n,
  snake_game_ctrl_if.slave  bus
);

  localparam logic signed [10:0] CELL_S  = 11'(CELL);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

  game_state_t state_q;
  move_t       committed_q, pending_q, pending_d, move_q;
  move_t       req_dir, dir_ref;
  logic        req_valid;
  logic        step_q, running_q, lose_q;
  logic [7:0]  score_q;
  logic        tick;
  logic        wall;
  logic signed [10:0] hx, hy, nx, ny;

  snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (clk25),
    .rst_ni (rst_n),
    .clr_i  (state_q != ST_RUN),
    .tick_o (tick)
  );

  // Button arbitration: priority pick first, then drop reversals and repeats.
  // On a tick the reference is pending_q, the dir about to be committed, so a
  // same-cycle request cannot queue a reversal of the new heading.
  always_comb begin
    req_valid = 1'b1;
    req_dir   = MV_RIGHT;
    if      (bus.btn_right) req_dir = MV_RIGHT;
    else if (bus.btn_up)    req_dir = MV_UP;
    else if (bus.btn_left)  req_dir = MV_LEFT;
    else if (bus.btn_down)  req_dir = MV_DOWN;
    else                    req_valid = 1'b0;
    dir_ref = tick ? pending_q : committed_q;
    if (req_dir == dir_ref || is_reverse(req_dir, dir_ref)) req_valid = 1'b0;
    pending_d = req_valid ? req_dir : pending_q;
  end

  // Next-head wall check in signed 11-bit space.
  always_comb begin
    hx = signed'({1'b0, bus.head_x});
    hy = signed'({1'b0, bus.head_y});
    nx = hx;
    ny = hy;
    case (pending_q)
      MV_RIGHT: nx = hx + CELL_S;
      MV_LEFT:  nx = hx - CELL_S;
      MV_UP:    ny = hy - CELL_S;
      MV_DOWN:  ny = hy + CELL_S;
      default: ;
    endcase
    wall = (nx < 11'sd0) || (nx > X_MAX_S) || (ny < 11'sd0) || (ny > Y_MAX_S);
  end

  // Game FSM with registered outputs; self hit outranks wall hit outranks step.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      committed_q <= MV_RIGHT;
      pending_q   <= MV_RIGHT;
      move_q      <= MV_HOLD;
      step_q      <= 1'b0;
      running_q   <= 1'b0;
      lose_q      <= 1'b0;
      score_q     <= '0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          move_q    <= MV_HOLD;
          running_q <= 1'b0;
          lose_q    <= 1'b0;
          if (bus.start) begin
            state_q     <= ST_RUN;
            running_q   <= 1'b1;
            move_q      <= MV_RIGHT;
            committed_q <= MV_RIGHT;
            pending_q   <= MV_RIGHT;
            score_q     <= '0;
          end
        end
        ST_RUN: begin
          if (bus.apple_hit && score_q != 8'hFF) score_q <= score_q + 8'd1;
          if (bus.self_hit || (tick && wall)) begin
            state_q   <= ST_DEAD;
            running_q <= 1'b0;
            lose_q    <= 1'b1;
            move_q    <= MV_HOLD;
          end else if (tick) begin
            committed_q <= pending_q;
            move_q      <= pending_q;
            step_q      <= 1'b1;
            pending_q   <= pending_d;
          end else begin
            pending_q <= pending_d;
          end
        end
        ST_DEAD: begin
          move_q <= MV_HOLD;
          if (bus.start) begin
            state_q <= ST_IDLE;
            lose_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.move    = move_q;
  assign bus.step    = step_q;
  assign bus.running = running_q;
  assign bus.lose    = lose_q;
  assign bus.score   = score_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with TICK_DIV=4.
module tb_snake_game_ctrl;

  logic clk25;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  snake_game_ctrl_if bus ();

  snake_game_ctrl #(
    .TICK_DIV (4),
    .CELL     (20),
    .X_MAX    (620),
    .Y_MAX    (460)
  ) dut (
    .clk25 (clk25),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  // btn packed as {right, up, left, down}
  typedef struct {
    logic       start;
    logic [3:0] btn;
    logic [2:0] exp_mv;
    logic       exp_step;
  } vec_t;

  vec_t vt[21];

  function automatic logic [13:0] pk(input logic [2:0] mv, input logic st,
                                     input logic run, input logic lo,
                                     input logic [7:0] sc);
    return {mv, st, run, lo, sc};
  endfunction

  function automatic logic [13:0] outs();
    return {bus.move, bus.step, bus.running, bus.lose, bus.score};
  endfunction

  task automatic chk(input string name, input logic [13:0] got, input logic [13:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got move=%b step=%b run=%b lose=%b score=%0d, expected move=%b step=%b run=%b lose=%b score=%0d",
               name, got[13:11], got[10], got[9], got[8], got[7:0],
               exp[13:11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic cyc();
    @(posedge clk25);
    #1;
  endtask

  task automatic clr_inputs();
    bus.start     = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_up    = 1'b0;
    bus.btn_left  = 1'b0;
    bus.btn_down  = 1'b0;
    bus.head_x    = 10'd300;
    bus.head_y    = 10'd240;
    bus.self_hit  = 1'b0;
    bus.apple_hit = 1'b0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clr_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_state", outs(), pk(3'b100, 1'b0, 1'b0, 1'b0, 8'd0));
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_hold", outs(), pk(3'b100, 1'b0, 1'b0, 1'b0, 8'd0));

    // Start, step cadence, ignored reverse/start, two requests within a tick,
    // request arriving on the tick cycle, multi-button priority.
    vt[0]  = '{1'b1, 4'b0000, 3'b000, 1'b0};
    vt[1]  = '{1'b0, 4'b0000, 3'b000, 1'b0};
    vt[2]  = '{1'b0, 4'b0000, 3'b000, 1'b0};
    vt[3]  = '{1'b0, 4'b0000, 3'b000, 1'b0};
    vt[4]  = '{1'b0, 4'b0000, 3'b000, 1'b1};
    vt[5]  = '{1'b0, 4'b0010, 3'b000, 1'b0};
    vt[6]  = '{1'b1, 4'b0010, 3'b000, 1'b0};
    vt[7]  = '{1'b0, 4'b0010, 3'b000, 1'b0};
    vt[8]  = '{1'b0, 4'b0010, 3'b000, 1'b1};
    vt[9]  = '{1'b0, 4'b0100, 3'b000, 1'b0};
    vt[10] = '{1'b0, 4'b0001, 3'b000, 1'b0};
    vt[11] = '{1'b0, 4'b0000, 3'b000, 1'b0};
    vt[12] = '{1'b0, 4'b0000, 3'b011, 1'b1};
    vt[13] = '{1'b0, 4'b0000, 3'b011, 1'b0};
    vt[14] = '{1'b0, 4'b0000, 3'b011, 1'b0};
    vt[15] = '{1'b0, 4'b0010, 3'b011, 1'b0};
    vt[16] = '{1'b0, 4'b0100, 3'b010, 1'b1};
    vt[17] = '{1'b0, 4'b0101, 3'b010, 1'b0};
    vt[18] = '{1'b0, 4'b0000, 3'b010, 1'b0};
    vt[19] = '{1'b0, 4'b0000, 3'b010, 1'b0};
    vt[20] = '{1'b0, 4'b0000, 3'b001, 1'b1};

    for (int i = 0; i < 21; i++) begin
      bus.start     = vt[i].start;
      bus.btn_right = vt[i].btn[3];
      bus.btn_up    = vt[i].btn[2];
      bus.btn_left  = vt[i].btn[1];
      bus.btn_down  = vt[i].btn[0];
      cyc();
      chk($sformatf("vec%0d", i), outs(), pk(vt[i].exp_mv, vt[i].exp_step, 1'b1, 1'b0, 8'd0));
    end
    clr_inputs();

    // Right wall: 600 -> 620 is legal, 620 -> 640 is a hit.
    do_reset();
    bus.head_x = 10'd600;
    start_pulse();
    chk("wall_start", outs(), pk(3'b000, 1'b0, 1'b1, 1'b0, 8'd0));
    repeat (4) cyc();
    chk("wall_right_edge_ok", outs(), pk(3'b000, 1'b1, 1'b1, 1'b0, 8'd0));
    bus.head_x = 10'd620;
    repeat (3) cyc();
    chk("wall_right_pre", outs(), pk(3'b000, 1'b0, 1'b1, 1'b0, 8'd0));
    cyc();
    chk("wall_right", outs(), pk(3'b100, 1'b0, 1'b0, 1'b1, 8'd0));

    // Top wall with dir up: 20 -> 0 legal, 0 -> -20 is a hit.
    do_reset();
    start_pulse();
    bus.btn_up = 1'b1;
    cyc();
    bus.btn_up = 1'b0;
    repeat (3) cyc();
    chk("up_commit", outs(), pk(3'b001, 1'b1, 1'b1, 1'b0, 8'd0));
    bus.head_y = 10'd20;
    repeat (4) cyc();
    chk("wall_top_edge_ok", outs(), pk(3'b001, 1'b1, 1'b1, 1'b0, 8'd0));
    bus.head_y = 10'd0;
    repeat (4) cyc();
    chk("wall_top", outs(), pk(3'b100, 1'b0, 1'b0, 1'b1, 8'd0));

    // Score saturation, then self hit on a tick cycle (cycle 260).
    do_reset();
    start_pulse();
    bus.apple_hit = 1'b1;
    cyc();
    chk("apple_first", outs(), pk(3'b000, 1'b0, 1'b1, 1'b0, 8'd1));
    repeat (256) cyc();
    bus.apple_hit = 1'b0;
    chk("apple_sat", 14'(bus.score), 14'd255);
    cyc();
    cyc();
    bus.self_hit = 1'b1;
    cyc();
    bus.self_hit = 1'b0;
    chk("self_on_tick", outs(), pk(3'b100, 1'b0, 1'b0, 1'b1, 8'd255));
    cyc();
    chk("dead_hold", outs(), pk(3'b100, 1'b0, 1'b0, 1'b1, 8'd255));

    // DEAD -> IDLE -> RUN, apple coincident with self hit, apple ignored in DEAD.
    start_pulse();
    chk("dead_to_idle", outs(), pk(3'b100, 1'b0, 1'b0, 1'b0, 8'd255));
    start_pulse();
    chk("restart", outs(), pk(3'b000, 1'b0, 1'b1, 1'b0, 8'd0));
    bus.apple_hit = 1'b1;
    bus.self_hit  = 1'b1;
    cyc();
    bus.self_hit = 1'b0;
    chk("apple_with_self", outs(), pk(3'b100, 1'b0, 1'b0, 1'b1, 8'd1));
    cyc();
    bus.apple_hit = 1'b0;
    chk("apple_in_dead", outs(), pk(3'b100, 1'b0, 1'b0, 1'b1, 8'd1));

    // Asynchronous reset between steps, then no stray step afterwards.
    do_reset();
    start_pulse();
    repeat (4) cyc();
    chk("pre_reset_step", outs(), pk(3'b000, 1'b1, 1'b1, 1'b0, 8'd0));
    cyc();
    chk("pre_reset_run", outs(), pk(3'b000, 1'b0, 1'b1, 1'b0, 8'd0));
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), pk(3'b100, 1'b0, 1'b0, 1'b0, 8'd0));
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk($sformatf("post_reset%0d", i), outs(), pk(3'b100, 1'b0, 1'b0, 1'b0, 8'd0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
